// File: rtl/apb_sw_led_gpio.sv
// APB switch/LED peripheral: synchronises and debounces a 32-bit switch vector,
// drives a 32-bit LED register and raises a level interrupt on enabled switch changes.
module apb_sw_led_gpio #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ADDR_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [31:0]       SW,
  output logic [31:0]       LED,
  output logic              irq
);

  localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

  logic [31:0] s1_q, s2_q;
  logic [31:0] cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] stable_q, stable_d;
  logic [31:0] led_q, led_d;
  logic [31:0] chg_q, chg_d;
  logic [31:0] en_q, en_d;
  logic        irq_q, irq_d;
  logic [31:0] commit_set;
  logic [31:0] chg_clr;
  logic        access, addr_hi, wr;
  logic [1:0]  sel;
  logic        unused_addr_bits;

  assign access           = PSEL & PENABLE;
  assign sel              = PADDR[3:2];
  assign wr               = access & PWRITE & ~addr_hi;
  assign unused_addr_bits = ^PADDR[1:0];

  // Any address bit above the 16-byte window makes the access unmapped.
  always_comb begin
    addr_hi = 1'b0;
    for (int unsigned i = 4; i < ADDR_W; i++) begin
      addr_hi = addr_hi | PADDR[i];
    end
  end

  // Debounce: one shared counter; a commit only happens after a full quiet window.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    commit_set = '0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q < CntLast) begin
      cnt_d = cnt_q + 16'd1;
    end else if (cand_q != stable_q) begin
      stable_d   = cand_q;
      commit_set = cand_q ^ stable_q;
    end
  end

  // Register writes; a commit setting a SW_CHG bit beats a same-cycle W1C.
  always_comb begin
    led_d   = led_q;
    en_d    = en_q;
    chg_clr = '0;
    if (wr) begin
      unique case (sel)
        2'd1:    led_d   = PWDATA;
        2'd2:    chg_clr = PWDATA;
        2'd3:    en_d    = PWDATA;
        default: ;
      endcase
    end
    chg_d = (chg_q & ~chg_clr) | commit_set;
    irq_d = |(chg_d & en_d);
  end

  // Read mux and error response, forced low while reset is held.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = access & addr_hi & reset;
    if (access && !addr_hi && reset) begin
      unique case (sel)
        2'd0:    PRDATA = stable_q;
        2'd1:    PRDATA = led_q;
        2'd2:    PRDATA = chg_q;
        default: PRDATA = en_q;
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      led_q    <= '0;
      chg_q    <= '0;
      en_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      s1_q     <= SW;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      led_q    <= led_d;
      chg_q    <= chg_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

  assign PREADY = 1'b1;
  assign LED    = led_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_apb_sw_led_gpio.sv
module tb_apb_sw_led_gpio;

  logic        clk;
  logic        reset;
  logic        PSEL, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA, SW, LED;
  logic        PREADY, PSLVERR, irq;

  int checks = 0;
  int errors = 0;

  apb_sw_led_gpio #(.DEBOUNCE_CYCLES(16), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .SW      (SW),
    .LED     (LED),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    err = PSLVERR;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; SW = '0;
    #13;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    do_reset();
    checks++; if (LED !== 32'h0) begin errors++; $display("FAIL reset_led got %h want 0", LED); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL reset_pready got %b want 1", PREADY); end
    for (int a = 0; a < 4; a++) begin
      apb_read(5'(a * 4), d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        errors++; $display("FAIL reset_read addr %0h got %h err %b want 0 err 0", a * 4, d, e);
      end
    end
  endtask

  task automatic test_led();
    logic [31:0] d;
    logic        e;
    apb_write(5'h4, 32'hA5A5_0F0F, e);
    checks++; if (LED !== 32'hA5A5_0F0F) begin errors++; $display("FAIL led_write got %h want a5a50f0f", LED); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL led_wr_err got %b want 0", e); end
    apb_read(5'h4, d, e);
    checks++; if (d !== 32'hA5A5_0F0F || e !== 1'b0) begin
      errors++; $display("FAIL led_read got %h err %b want a5a50f0f err 0", d, e);
    end
  endtask

  // SW is driven at a negedge; the next posedge samples it and the commit lands
  // 18 posedges after that sampling edge (19 posedges after the drive).
  task automatic test_debounce();
    logic [31:0] d;
    logic        e;
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 5'h0; SW = 32'h3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (PRDATA !== ((k >= 19) ? 32'h3 : 32'h0)) begin
        errors++; $display("FAIL debounce_cycle %0d got %h want %h", k, PRDATA, (k >= 19) ? 32'h3 : 32'h0);
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(5'h8, d, e);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL debounce_chg got %h want 3", d); end

    // Second run: a one-cycle glitch on bit 0 restarts the window.
    do_reset();
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 5'h0; SW = 32'h3;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 9) SW = 32'h2;
      if (k == 10) SW = 32'h3;
      if (k == 18 || k == 19 || k == 28 || k == 29 || k == 30) begin
        checks++;
        if (PRDATA !== ((k >= 29) ? 32'h3 : 32'h0)) begin
          errors++; $display("FAIL glitch_cycle %0d got %h want %h", k, PRDATA, (k >= 29) ? 32'h3 : 32'h0);
        end
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(5'h8, d, e);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL glitch_chg got %h want 3", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        e;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
    apb_write(5'hC, 32'h1, e);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable got %b want 1", irq); end
    apb_write(5'h8, 32'h1, e);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b want 0", irq); end
    apb_read(5'h8, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_chg got %h want 2", d); end

    // Commit of bit 0 (SW 3 -> 2) lands on the access edge of a W1C of bit 0.
    @(negedge clk);
    SW = 32'h2;
    repeat (16) @(negedge clk);
    apb_write(5'h8, 32'h1, e);
    apb_read(5'h8, d, e);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL conflict_chg got %h want 3", d); end
    apb_read(5'h0, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL conflict_stable got %h want 2", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL conflict_irq got %b want 1", irq); end
  endtask

  task automatic test_ro_unmapped();
    logic [31:0] d;
    logic        e;
    apb_write(5'h0, 32'hFFFF_FFFF, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ro_err got %b want 0", e); end
    apb_read(5'h0, d, e);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ro_stable got %h want 2", d); end
    apb_write(5'h4, 32'h1234_5678, e);
    apb_write(5'h14, 32'hDEAD_BEEF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmapped_wr_err got %b want 1", e); end
    checks++; if (LED !== 32'h1234_5678) begin errors++; $display("FAIL unmapped_led got %h want 12345678", LED); end
    apb_write(5'h1C, 32'h0, e);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmapped_irq got %b want 1", irq); end
    apb_read(5'h10, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL unmapped_rd got %h err %b want 0 err 1", d, e);
    end
    // Setup phase only: no read data, no error, no write side effect.
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h4; PWDATA = 32'h0;
    #1;
    checks++; if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
      errors++; $display("FAIL setup_only got %h err %b want 0 err 0", PRDATA, PSLVERR);
    end
    @(negedge clk);
    PSEL = 1'b0;
    checks++; if (LED !== 32'h1234_5678) begin errors++; $display("FAIL setup_led got %h want 12345678", LED); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        e;
    apb_write(5'h4, 32'hFF, e);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h4; PWDATA = 32'h55;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++; if (LED !== 32'h0) begin errors++; $display("FAIL async_led got %h want 0", LED); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq got %b want 0", irq); end
    PSEL = 1'b0; PENABLE = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (LED !== 32'h0) begin errors++; $display("FAIL async_abandon got %h want 0", LED); end
    apb_write(5'h4, 32'h77, e);
    checks++; if (LED !== 32'h77) begin errors++; $display("FAIL post_reset_led got %h want 77", LED); end
    apb_read(5'h8, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_chg got %h want 0", d); end
    apb_read(5'h0, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_stable got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_debounce();
    test_irq();
    test_ro_unmapped();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
